// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Scan controller for a 2**SEL_W-to-1 select mux. On an accepted start it
//   drives a latched word onto the mux data inputs and steps the select from
//   0 to 2**SEL_W-1. At each step it waits SETTLE cycles, then samples the
//   mux output, so the word is rebuilt one bit at a time. The rebuilt word
//   and a compare-against-source flag are offered on a valid/ready handshake.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   start       in   begin a scan (accepted only when idle)
//   load_data   in   word to scan, captured when start is accepted
//   mux_in      out  registered word driven onto the mux data inputs
//   sel         out  registered mux select
//   mux_out     in   mux output (combinational from mux_in/sel)
//   data_out    out  rebuilt word
//   data_valid  out  data_out/mismatch valid
//   data_ready  in   consumer accepts the result
//   mismatch    out  rebuilt word differs from mux_in
//   busy        out  controller not idle
module mux_scan_ctrl #(
    parameter int SEL_W  = 3,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2**SEL_W-1:0]   load_data,
    output logic [2**SEL_W-1:0]   mux_in,
    output logic [SEL_W-1:0]      sel,
    input  logic                  mux_out,
    output logic [2**SEL_W-1:0]   data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  mismatch,
    output logic                  busy
);

    localparam int N     = 2**SEL_W;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [SEL_W-1:0] SEL_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     capture;
    logic [N-1:0]     cap_next;

    // Capture register with the current bit merged in; on the last step this
    // is the completed word, which is what data_out and mismatch must see.
    always_comb begin
        cap_next      = capture;
        cap_next[sel] = mux_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mux_in     <= '0;
            sel        <= '0;
            cnt        <= '0;
            capture    <= '0;
            data_out   <= '0;
            mismatch   <= 1'b0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mux_in  <= load_data;
                        sel     <= '0;
                        cnt     <= CNT_INIT;
                        capture <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SETTLE;
                    end
                end

                // Counter starts at SETTLE-1 and the SAMPLE state adds one
                // more edge, so each bit spans SETTLE+1 edges.
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    capture <= cap_next;
                    if (sel == SEL_MAX) begin
                        // sel is left at its last value; no wrap.
                        data_out   <= cap_next;
                        mismatch   <= (cap_next != mux_in);
                        data_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        sel   <= sel + 1'b1;
                        cnt   <= CNT_INIT;
                        state <= ST_SETTLE;
                    end
                end

                // start is not looked at here; it must be reasserted in IDLE.
                ST_DONE: begin
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Scan controller that drives the 8-to-1 select mux and consumes its single-bit output. On `start` it latches an 8-bit word onto the mux data inputs and steps `sel` from 0 to 7. After a programmable settle time at each step it samples `mux_out` and rebuilds the word. It then presents the rebuilt word and a mismatch flag on a valid/ready handshake, which gives a self-checking readback path around the mux.

## Interface
- `SEL_W`, default 3: select width. The mux has 2**SEL_W data inputs (8 at default).
- `SETTLE`, default 1: cycles `sel` is held before each sample. Legal range is at least 1.
- `clk`  in  1  : single clock. Everything is rising-edge.
- `rst_n`  in  1  : synchronous, active-low reset. Sampled on the `clk` rising edge.
- `start`  in  1  : begin a scan. Accepted only in IDLE.
- `load_data`  in  2**SEL_W  : word to scan. Captured when `start` is accepted.
- `mux_in`  out  2**SEL_W  : registered word driven onto the mux data inputs.
- `sel`  out  SEL_W  : registered mux select.
- `mux_out`  in  1  : mux output, which is combinational from `mux_in` and `sel`.
- `data_out`  out  2**SEL_W  : rebuilt word.
- `data_valid`  out  1  : `data_out` and `mismatch` are valid.
- `data_ready`  in  1  : consumer accepts the result.
- `mismatch`  out  1  : 1 when `data_out` differs from `mux_in`.
- `busy`  out  1  : high whenever the controller is not in IDLE.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On `start`=1, load `mux_in`<=`load_data`, `sel`<=0, settle counter<=SETTLE-1, capture register<=0.
  - Then go to SETTLE.
- SETTLE: decrement the counter each cycle. When the counter is 0, go to SAMPLE.
- SAMPLE:
  - Store `capture[sel]`<=`mux_out`.
  - If `sel`==2**SEL_W-1: load `data_out`<=the completed capture and `mismatch`<=(completed capture != `mux_in`), then go to DONE.
  - Otherwise: `sel`<=`sel`+1, counter<=SETTLE-1, go to SETTLE.
- DONE: `data_valid`=1. On `data_ready`=1, go to IDLE.
- `data_valid`, `busy` and `sel` are registered and decoded from state. None of them depend combinationally on inputs.
- `sel` does not wrap. It stops at 7 and holds its last value until the next accepted `start`.
- Bit mapping: bit i of `data_out` equals `mux_out` sampled while `sel`==i.
- `start` outside IDLE is ignored and not queued.
- `start` and `data_ready` together in DONE: go to IDLE only. `start` must be reasserted in IDLE.
- `data_out` and `mismatch` hold their values after the handshake until the next scan completes.
- `load_data` changes after acceptance have no effect on the scan in progress.
- Reset:
  - `rst_n`=0 at any edge, including mid-scan, forces IDLE on that edge.
  - All outputs go to 0: `mux_in`, `sel`, `data_out`, `data_valid`, `mismatch`, `busy`.
  - The capture register and settle counter are also cleared.

## Timing
- Let E0 be the edge where `start` is accepted. `busy`=1 and `sel`=0 from E0.
- Each bit takes SETTLE+1 edges. `sel` advances at E0+k·(SETTLE+1) for k=1..7.
- The last sample is taken at E0+8·(SETTLE+1). `data_valid` rises at that edge: 16 cycles at SETTLE=1, 32 cycles at SETTLE=3.
- `mux_out` is sampled at least SETTLE cycles after the `sel`/`mux_in` update, which absorbs the mux's combinational delay.
- Handshake completes on the edge where `data_valid`&&`data_ready`. `data_valid` and `busy` are 0 after that edge.
- The earliest next `start` is accepted on the edge after the handshake edge.
- Under backpressure, `data_valid`, `data_out` and `mismatch` stay stable for as long as `data_ready`=0.

## Test plan
- Reset: hold `rst_n`=0 for 3 edges with random inputs -> `sel`=0, `mux_in`=0, `data_out`=0, `data_valid`=0, `busy`=0, `mismatch`=0.
- Nominal scan, SETTLE=1, behavioural 8:1 mux, `data_ready`=1, `start` with `load_data`=8'b10101010 -> `sel` steps 0..7 every 2 cycles; `data_valid` rises 16 edges after E0 for exactly 1 cycle; `data_out`=8'hAA, `mismatch`=0.
- Backpressure: `load_data`=8'h3C, `data_ready`=0 for 5 cycles after valid -> `data_out`=8'h3C held stable with `data_valid`=1 throughout; one `data_ready` pulse -> `data_valid`=0 and `busy`=0 on the next edge.
- Fault detection: mux output forced to 0, `load_data`=8'hFF -> `data_out`=8'h00, `mismatch`=1. Also swap mux bits 2 and 5 with `load_data`=8'h04 -> `data_out`=8'h20, `mismatch`=1.
- Control boundaries:
  - `start` pulsed while `sel`=4 -> ignored; result still matches the original word.
  - `rst_n`=0 for one edge at `sel`=3 -> all outputs 0 on that edge.
  - A new `start` with 8'h5A afterwards -> `data_out`=8'h5A.
- SETTLE=3 with `load_data`=8'h81 -> `sel` advances every 4 cycles; `data_valid` rises 32 edges after E0; `data_out`=8'h81.
